// File: rtl/rtc_stamp_capture.sv
// RTC event timestamp capture: reads time then date over the reg bus on each event edge and queues {id, date, time}.
// Optional: define RTC_STAMP_COHERENT_EN to re-read time after date and retry once on rollover tearing.
module rtc_stamp_capture #(
   parameter int          NUM_EVT    = 4,
   parameter int          FIFO_DEPTH = 4,
   parameter logic [4:0]  TIME_ADDR  = 5'h00,
   parameter logic [4:0]  DATE_ADDR  = 5'h01,
   parameter int          TIMEOUT    = 15,
   localparam int         ID_W       = (NUM_EVT > 1) ? $clog2(NUM_EVT) : 1,
   localparam int         PTR_W      = $clog2(FIFO_DEPTH),
   localparam int         CNT_W      = $clog2(FIFO_DEPTH) + 1,
   localparam int         ENT_W      = 64 + ID_W
) (
   input  logic               rtc_clk,
   input  logic               rst,
   input  logic [NUM_EVT-1:0] evt_in,
   output logic               reg_cs,
   output logic [4:0]         reg_addr,
   output logic [31:0]        reg_wdata,
   output logic [3:0]         reg_be,
   output logic               reg_wr,
   input  logic [31:0]        reg_rdata,
   input  logic               reg_ack,
   input  logic               ts_rd,
   output logic               ts_valid,
   output logic [ENT_W-1:0]   ts_rdata,
   output logic [CNT_W-1:0]   ts_count,
   output logic               ts_ovf,
   output logic               ts_err,
   output logic               evt_miss,
   input  logic               flag_clr
);
   localparam int WAIT_W = $clog2(TIMEOUT + 1);

`ifdef RTC_STAMP_COHERENT_EN
   typedef enum logic [2:0] {S_IDLE, S_RD_TIME, S_GAP, S_RD_DATE, S_PUSH,
                             S_GAP2, S_RD_TIME2, S_RETRY} state_t;
`else
   typedef enum logic [2:0] {S_IDLE, S_RD_TIME, S_GAP, S_RD_DATE, S_PUSH} state_t;
`endif

   state_t               state, nxt;
   logic [NUM_EVT-1:0]   evt_d, pending, edges, clr_mask;
   logic                 arb_hit, take;
   logic [ID_W-1:0]      arb_id, cur_id;
   logic [31:0]          time_r, date_r;
   logic [WAIT_W-1:0]    wcnt;
   logic                 acked, tmo, tear_err;
   logic [ENT_W-1:0]     mem [FIFO_DEPTH];
   logic [PTR_W-1:0]     wr_ptr, rd_ptr;
   logic                 full, empty, do_pop, do_push, drop;
`ifdef RTC_STAMP_COHERENT_EN
   logic                 retried;
`endif

   assign reg_wdata = '0;
   assign reg_be    = 4'hF;
   assign reg_wr    = 1'b0;

   // Lowest index wins; scan downward so the last hit is the smallest index.
   always_comb begin
      arb_hit = 1'b0;
      arb_id  = '0;
      for (int i = NUM_EVT - 1; i >= 0; i--)
         if (pending[i]) begin
            arb_hit = 1'b1;
            arb_id  = ID_W'(i);
         end
   end

   assign take  = (state == S_IDLE) && arb_hit;
   assign edges = evt_in & ~evt_d;
   assign acked = reg_cs && reg_ack;
   assign tmo   = reg_cs && !reg_ack && (wcnt == WAIT_W'(TIMEOUT - 1));

   always_comb begin
      clr_mask = '0;
      if (take) clr_mask[arb_id] = 1'b1;
   end

   always_ff @(posedge rtc_clk) begin
      if (rst) state <= S_IDLE;
      else     state <= nxt;
   end

   always_comb begin
      nxt      = state;
      tear_err = 1'b0;
      case (state)
         S_IDLE:    if (arb_hit) nxt = S_RD_TIME;
         S_RD_TIME: if (acked) nxt = S_GAP; else if (tmo) nxt = S_IDLE;
         S_GAP:     nxt = S_RD_DATE;
`ifdef RTC_STAMP_COHERENT_EN
         S_RD_DATE: if (acked) nxt = S_GAP2; else if (tmo) nxt = S_IDLE;
         S_GAP2:    nxt = S_RD_TIME2;
         S_RD_TIME2:
            if (acked) begin
               if (reg_rdata == time_r) nxt = S_PUSH;
               else if (!retried)       nxt = S_RETRY;
               else begin
                  nxt      = S_PUSH;
                  tear_err = 1'b1;
               end
            end else if (tmo) nxt = S_IDLE;
         S_RETRY:   nxt = S_RD_TIME;
`else
         S_RD_DATE: if (acked) nxt = S_PUSH; else if (tmo) nxt = S_IDLE;
`endif
         S_PUSH:    nxt = S_IDLE;
         default:   nxt = S_IDLE;
      endcase
   end

   always_comb begin
      reg_cs   = 1'b0;
      reg_addr = '0;
      case (state)
         S_RD_TIME:  begin reg_cs = 1'b1; reg_addr = TIME_ADDR; end
         S_RD_DATE:  begin reg_cs = 1'b1; reg_addr = DATE_ADDR; end
`ifdef RTC_STAMP_COHERENT_EN
         S_RD_TIME2: begin reg_cs = 1'b1; reg_addr = TIME_ADDR; end
`endif
         default:    ;
      endcase
   end

   assign full    = (ts_count == CNT_W'(FIFO_DEPTH));
   assign empty   = (ts_count == '0);
   assign do_pop  = ts_rd && !empty;
   assign do_push = (state == S_PUSH) && (!full || do_pop);
   assign drop    = (state == S_PUSH) && full && !do_pop;

   assign ts_valid = !empty;
   assign ts_rdata = empty ? '0 : mem[rd_ptr];

   always_ff @(posedge rtc_clk)
      if (do_push) mem[wr_ptr] <= {cur_id, date_r, time_r};

   always_ff @(posedge rtc_clk) begin
      evt_d <= evt_in;
      if (rst) begin
         pending  <= '0;
         cur_id   <= '0;
         time_r   <= '0;
         date_r   <= '0;
         wcnt     <= '0;
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         ts_count <= '0;
         ts_ovf   <= 1'b0;
         ts_err   <= 1'b0;
         evt_miss <= 1'b0;
`ifdef RTC_STAMP_COHERENT_EN
         retried  <= 1'b0;
`endif
      end else begin
         // An edge landing in the clear cycle re-arms the bit without counting as a miss.
         pending <= (pending & ~clr_mask) | edges;
         if (|(edges & pending & ~clr_mask)) evt_miss <= 1'b1;
         else if (flag_clr)                  evt_miss <= 1'b0;

         if (take) cur_id <= arb_id;
         if (reg_cs && !reg_ack && !tmo) wcnt <= wcnt + 1'b1;
         else                            wcnt <= '0;

         if (acked && reg_addr == DATE_ADDR) date_r <= reg_rdata;
         else if (acked)                     time_r <= reg_rdata;

`ifdef RTC_STAMP_COHERENT_EN
         if (take)                retried <= 1'b0;
         else if (nxt == S_RETRY) retried <= 1'b1;
`endif

         if (tmo || tear_err) ts_err <= 1'b1;
         else if (flag_clr)   ts_err <= 1'b0;

         if (drop)          ts_ovf <= 1'b1;
         else if (flag_clr) ts_ovf <= 1'b0;

         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
         ts_count <= ts_count + CNT_W'(do_push) - CNT_W'(do_pop);
      end
   end
endmodule

// File: tb/tb_rtc_stamp_capture.sv
// Scoreboard bench for rtc_stamp_capture: a bus responder feeds time/date words, a monitor pops and checks stamps.
module tb_rtc_stamp_capture;
   localparam int NUM_EVT = 4;
   localparam int ID_W    = 2;
   localparam int ENT_W   = 64 + ID_W;

   logic               clk = 1'b0;
   logic               rst, reg_cs, reg_wr, reg_ack, ts_rd, ts_valid, ts_ovf, ts_err, evt_miss, flag_clr;
   logic [NUM_EVT-1:0] evt_in;
   logic [4:0]         reg_addr;
   logic [31:0]        reg_wdata, reg_rdata;
   logic [3:0]         reg_be;
   logic [ENT_W-1:0]   ts_rdata;
   logic [2:0]         ts_count;

   rtc_stamp_capture dut (
      .rtc_clk(clk), .rst(rst), .evt_in(evt_in),
      .reg_cs(reg_cs), .reg_addr(reg_addr), .reg_wdata(reg_wdata), .reg_be(reg_be),
      .reg_wr(reg_wr), .reg_rdata(reg_rdata), .reg_ack(reg_ack),
      .ts_rd(ts_rd), .ts_valid(ts_valid), .ts_rdata(ts_rdata), .ts_count(ts_count),
      .ts_ovf(ts_ovf), .ts_err(ts_err), .evt_miss(evt_miss), .flag_clr(flag_clr)
   );

   always #5 clk = ~clk;

   int nvec = 0, nmis = 0;
   logic [ENT_W-1:0] exp_q[$];
   logic [31:0]      time_q[$], date_q[$];
   logic [4:0]       addr_log[$];
   int               ack_dly = 0;
   bit               rsp_en  = 1'b1;
   bit               rd_en   = 1'b0;

   task automatic check(input string nm, input logic [95:0] act, input logic [95:0] exp);
      nvec++;
      if (act !== exp) begin
         nmis++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   // Register-bus responder: acks after ack_dly wait cycles
   initial begin
      int wc = 0;
      reg_ack = 1'b0; reg_rdata = '0;
      forever begin
         @(negedge clk);
         reg_ack = 1'b0; reg_rdata = '0;
         if (reg_cs && !rst) begin
            if (rsp_en && wc >= ack_dly) begin
               reg_ack = 1'b1;
               addr_log.push_back(reg_addr);
               if (reg_addr == 5'h01) reg_rdata = (date_q.size() > 0) ? date_q.pop_front() : 32'hDEAD_DA7E;
               else                   reg_rdata = (time_q.size() > 0) ? time_q.pop_front() : 32'hDEAD_0000;
               wc = 0;
            end else wc++;
         end else wc = 0;
      end
   end

   // Monitor: pops and compares the head whenever a stamp is presented
   initial begin
      ts_rd = 1'b0;
      forever begin
         @(negedge clk);
         ts_rd = 1'b0;
         if (rd_en && ts_valid && !rst) begin
            if (exp_q.size() == 0) check("sb_extra", ts_rdata, '0);
            else                   check("sb_stamp", ts_rdata, exp_q.pop_front());
            ts_rd = 1'b1;
         end
      end
   end

   task automatic wait_count(input int c, input string nm);
      int n = 0;
      while (ts_count != 3'(c) && n < 200) begin @(negedge clk); n++; end
      check(nm, ts_count, c);
   endtask

   task automatic wait_drain(input string nm);
      int n = 0;
      while ((exp_q.size() != 0 || ts_valid) && n < 300) begin @(negedge clk); n++; end
      check(nm, exp_q.size(), 0);
   endtask

   task automatic pulse(input logic [NUM_EVT-1:0] v);
      evt_in = v;
      @(negedge clk);
      evt_in = '0;
   endtask

   initial begin
      int cs_seen, n;
      rst = 1'b1; evt_in = 4'b1000; flag_clr = 1'b0;
      repeat (3) @(negedge clk);
      check("rst_cs", reg_cs, 0);
      check("rst_valid", ts_valid, 0);
      check("rst_count", ts_count, 0);
      check("rst_rdata", ts_rdata, 0);
      check("rst_flags", {ts_ovf, ts_err, evt_miss}, 0);
      rst = 1'b0;
      cs_seen = 0;
      repeat (6) begin @(negedge clk); cs_seen += int'(reg_cs); end
      check("level_no_event", cs_seen, 0);
      evt_in = '0;
      @(negedge clk);

      // 1: single event, ack after 3 waits
      ack_dly = 3; addr_log.delete();
      time_q.push_back(32'h0012_3045); date_q.push_back(32'h2022_1118);
      exp_q.push_back({2'd2, 32'h2022_1118, 32'h0012_3045});
      evt_in = 4'b0100;
      @(negedge clk);
      check("lat_cs_lo", reg_cs, 0);
      @(negedge clk);
      check("lat_cs_hi", reg_cs, 1);
      check("addr_time", reg_addr, 5'h00);
      check("bus_static", {reg_wr, reg_be, reg_wdata}, {1'b0, 4'hF, 32'h0});
      evt_in = '0;
      wait_count(1, "t1_count");
      check("t1_head", ts_rdata, {2'd2, 32'h2022_1118, 32'h0012_3045});
      check("t1_addr_seq", {addr_log.size() == 2 ? addr_log[0] : 5'h1F, addr_log.size() == 2 ? addr_log[1] : 5'h1F}, {5'h00, 5'h01});
      rd_en = 1'b1;
      wait_drain("t1_drain");

      // 2: simultaneous events on 0 and 3
      ack_dly = 1;
      time_q.push_back(32'h0001_0000); date_q.push_back(32'h2023_0101);
      time_q.push_back(32'h0002_0000); date_q.push_back(32'h2023_0102);
      exp_q.push_back({2'd0, 32'h2023_0101, 32'h0001_0000});
      exp_q.push_back({2'd3, 32'h2023_0102, 32'h0002_0000});
      pulse(4'b1001);
      wait_drain("t2_drain");
      check("t2_no_miss", evt_miss, 0);

      // 3: five events into a 4-deep FIFO
      rd_en = 1'b0; ack_dly = 0;
      for (int k = 0; k < 5; k++) begin
         time_q.push_back(32'h100 + k); date_q.push_back(32'h2000 + k);
         if (k < 4) exp_q.push_back({2'd1, 32'h2000 + k, 32'h100 + k});
      end
      for (int k = 0; k < 5; k++) begin
         pulse(4'b0010);
         repeat (12) @(negedge clk);
      end
      check("t3_count", ts_count, 4);
      check("t3_ovf", ts_ovf, 1);
      check("t3_head", ts_rdata, {2'd1, 32'h2000, 32'h100});
      rd_en = 1'b1;
      wait_drain("t3_drain");
      check("t3_ovf_kept", ts_ovf, 1);
      flag_clr = 1'b1; @(negedge clk); flag_clr = 1'b0;
      check("t3_ovf_clr", ts_ovf, 0);

      // 4: bus timeout then normal service
      rsp_en = 1'b0;
      pulse(4'b1000);
      cs_seen = 0;
      repeat (40) begin @(negedge clk); cs_seen += int'(reg_cs); end
      check("t4_cs_cycles", cs_seen, 15);
      check("t4_err", ts_err, 1);
      check("t4_no_push", ts_count, 0);
      rsp_en = 1'b1; ack_dly = 2;
      time_q.push_back(32'h0003_0303); date_q.push_back(32'h2024_0404);
      exp_q.push_back({2'd2, 32'h2024_0404, 32'h0003_0303});
      pulse(4'b0100);
      wait_drain("t4_next");
      flag_clr = 1'b1; @(negedge clk); flag_clr = 1'b0;
      check("t4_err_clr", ts_err, 0);

      // 5: merged edge on evt_in[1] while busy on evt_in[0]
      ack_dly = 4;
      time_q.push_back(32'h0005_0000); date_q.push_back(32'h2025_0000);
      time_q.push_back(32'h0005_0001); date_q.push_back(32'h2025_0001);
      exp_q.push_back({2'd0, 32'h2025_0000, 32'h0005_0000});
      exp_q.push_back({2'd1, 32'h2025_0001, 32'h0005_0001});
      evt_in = 4'b0001; @(negedge clk);
      evt_in = 4'b0011; @(negedge clk);
      evt_in = 4'b0001; @(negedge clk);
      evt_in = 4'b0011; @(negedge clk);
      evt_in = '0;
      wait_drain("t5_drain");
      repeat (20) @(negedge clk);
      check("t5_one_stamp", ts_count, 0);
      check("t5_miss", evt_miss, 1);

      // reset in the middle of the date read
      ack_dly = 8;
      time_q.push_back(32'h0006_0000); date_q.push_back(32'h2026_0000);
      pulse(4'b0100);
      n = 0;
      while (!(reg_cs && reg_addr == 5'h01) && n < 100) begin @(negedge clk); n++; end
      check("t5_in_rd_date", {reg_cs, reg_addr}, {1'b1, 5'h01});
      rst = 1'b1; @(negedge clk);
      check("t5_rst_cs", reg_cs, 0);
      check("t5_rst_outs", {ts_valid, ts_count, ts_ovf, ts_err, evt_miss, reg_addr}, 0);
      check("t5_rst_rdata", ts_rdata, 0);
      rst = 1'b0;
      time_q.delete(); date_q.delete(); exp_q.delete();
      @(negedge clk);

`ifdef RTC_STAMP_COHERENT_EN
      // 6: midnight rollover between time and date reads
      ack_dly = 1;
      time_q.push_back(32'h0023_5959); date_q.push_back(32'h2022_1118);
      time_q.push_back(32'h0000_0000);
      time_q.push_back(32'h0000_0000); date_q.push_back(32'h2022_1119);
      time_q.push_back(32'h0000_0000);
      exp_q.push_back({2'd3, 32'h2022_1119, 32'h0000_0000});
      pulse(4'b1000);
      wait_drain("t6_drain");
      check("t6_err", ts_err, 0);
`endif

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
      $finish;
   end
endmodule

// File: doc/rtc_stamp_capture.md
Name: rtc_stamp_capture

Overview:
- Register-bus master sitting directly upstream of the RTC register block, in the rtc_clk domain.
- On a rising edge of any event input, reads the RTC time word then the date word over the reg interface.
- Tags the pair with the event id and pushes the 64-bit time+date stamp into a small FIFO for software or downstream readout.

Parameters:
NUM_EVT, 4, number of event inputs; ID_W = clog2(NUM_EVT), minimum 1
FIFO_DEPTH, 4, stamp FIFO entries; power of two, at least 2
TIME_ADDR, 5'h00, reg_addr of the packed time word
DATE_ADDR, 5'h01, reg_addr of the packed date word
TIMEOUT, 15, maximum cycles reg_cs may wait for reg_ack

Ports:
rtc_clk  in  1  RTC clock, 32768 Hz
rst  in  1  synchronous reset, active high
evt_in  in  NUM_EVT  event levels, synchronous to rtc_clk; rising edge = event
reg_cs  out  1  register access strobe
reg_addr  out  5  register address
reg_wdata  out  32  always 0
reg_be  out  4  always 4'hF
reg_wr  out  1  always 0 (read only)
reg_rdata  in  32  read data, valid with reg_ack
reg_ack  in  1  single-cycle access acknowledge
ts_rd  in  1  pop head entry (ignored when empty)
ts_valid  out  1  FIFO not empty
ts_rdata  out  64+ID_W  head entry {id, date, time}; 0 when empty
ts_count  out  clog2(FIFO_DEPTH)+1  occupancy
ts_ovf  out  1  sticky: stamp dropped, FIFO full
ts_err  out  1  sticky: bus timeout
evt_miss  out  1  sticky: event merged into an already-pending one
flag_clr  in  1  clears ts_ovf, ts_err, evt_miss

Behaviour:
- Reset (synchronous, dominant over all inputs):
  - all outputs 0, FIFO emptied, pending vector cleared, FSM in IDLE.
  - edge-detect history loads the current evt_in, so a level already high causes no event.
  - Reset mid-access drops reg_cs in the next cycle.
- Edge detect: evt_in & ~evt_d sets pending[i] one cycle after the edge.
  - An edge on an already-set pending bit sets evt_miss.
  - An edge in the same cycle the bit is cleared re-sets it; no miss.
- Arbitration in IDLE: lowest-index pending bit wins. Its id is latched and its pending bit cleared on leaving IDLE.
- FSM states: IDLE -> RD_TIME -> GAP -> RD_DATE -> PUSH -> IDLE.
  - RD_TIME/RD_DATE: reg_cs=1, reg_addr = TIME_ADDR or DATE_ADDR, held until reg_ack.
  - reg_rdata is captured in the reg_ack cycle; reg_cs is 0 in the following cycle.
  - GAP: exactly one cycle with reg_cs=0 between the two accesses.
  - Latency: reg_cs first high 2 cycles after the evt_in rising edge is sampled.
- Timeout:
  - A wait counter counts cycles with reg_cs=1 and no ack.
  - On reaching TIMEOUT, the FSM sets ts_err and drops reg_cs; it returns to IDLE with no push, and the event is lost.
  - A late ack with reg_cs=0 is ignored.
- PUSH: writes {id, date, time} to the tail; ts_valid and ts_count update the next cycle.
  - FIFO full and no ts_rd in the same cycle: entry dropped, ts_ovf set, FIFO unchanged.
  - FIFO full with ts_rd in the same cycle: push accepted, count unchanged.
- Read side: ts_rdata is show-ahead (combinational from the head). ts_rd while empty has no effect.
- Flags: flag_clr loses to a set event in the same cycle.
- Pointers wrap modulo FIFO_DEPTH; count saturates at FIFO_DEPTH.

Optional Feature:
RTC_STAMP_COHERENT_EN
- Defined:
  - After RD_DATE, FSM adds GAP2 and RD_TIME2 (one more time read).
  - If time2 differs from time1, the sequence restarts at RD_TIME once, reusing the same id.
  - A second mismatch pushes the last-read time/date and sets ts_err.
  - Guarantees no midnight-rollover tearing.
- Undefined: the single time+date pair is pushed unchecked; the GAP2/RD_TIME2 states do not exist.

Test Plan:
1. evt_in[2] 0->1 with ack after 3 cycles returning 32'h0012_3045 then 32'h2022_1118.
   - reg_cs high 2 cycles after the edge; addresses 0 then 1; reg_wr=0.
   - ts_rdata = {2'd2, 32'h2022_1118, 32'h0012_3045}; ts_count=1.
2. evt_in[0] and evt_in[3] rise in the same cycle.
   - Two stamps, id 0 first then id 3; no evt_miss.
3. Five events with no ts_rd (FIFO_DEPTH=4).
   - ts_count=4, ts_ovf=1; head entry is the first event.
   - Pop all four, then flag_clr -> ts_ovf=0.
4. reg_ack never asserted.
   - reg_cs drops after 15 cycles; ts_err=1; no push; the next event is serviced normally.
5. Second rising edge on evt_in[1] while its pending bit is set -> evt_miss=1, only one stamp.
   - Assert rst mid-RD_DATE -> next cycle reg_cs=0 and all outputs 0.
6. (COHERENT_EN) time reads 32'h0023_5959 then 32'h0000_0000 across the date change.
   - Sequence re-run; stamp holds the consistent second-pass time/date; ts_err=0.
